// File: rtl/b2t_encoder.sv
// Binary-to-temporal encoder: one race-logic edge per channel, placed at a phase equal to its value.
// Define B2T_PULSE_EN for pulse mode (PULSE_WIDTH-cycle pulse); the default build is step mode.
module b2t_encoder #(
  parameter int GAMMA_CYCLE_WIDTH = 16,
  parameter int PULSE_WIDTH       = 8,
  parameter int NUM_CHANNELS      = 16,
  parameter int VALUE_WIDTH       = 8
) (
  input  logic                                         aclk,
  input  logic                                         grst,
  input  logic                                         in_valid,
  output logic                                         in_ready,
  input  logic [NUM_CHANNELS-1:0][VALUE_WIDTH-1:0]     in_values,
  output logic [$clog2(GAMMA_CYCLE_WIDTH)-1:0]         phase,
  output logic                                         gamma_start,
  output logic                                         active,
  output logic [NUM_CHANNELS-1:0]                      t_out
);

  localparam int PHASE_W = $clog2(GAMMA_CYCLE_WIDTH);
  // Wide enough to hold either a value or a phase without truncating the value.
  localparam int CMP_W   = ((VALUE_WIDTH > PHASE_W) ? VALUE_WIDTH : PHASE_W) + 1;

  typedef logic [NUM_CHANNELS-1:0][VALUE_WIDTH-1:0] value_set_t;

  value_set_t          staged_vals;
  value_set_t          active_vals;
  value_set_t          active_vals_nxt;
  logic                staged_full;
  logic                staged_full_nxt;
  logic                active_nxt;
  logic                wrap;
  logic                accept;
  logic [PHASE_W-1:0]  phase_nxt;
  logic [NUM_CHANNELS-1:0] t_nxt;
  logic [CMP_W-1:0]    p_ext;

  assign wrap      = (phase == PHASE_W'(GAMMA_CYCLE_WIDTH - 1));
  assign accept    = in_valid && in_ready;
  assign phase_nxt = wrap ? '0 : phase + 1'b1;
  assign p_ext     = CMP_W'(phase_nxt);

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    active_nxt      = active;
    active_vals_nxt = active_vals;
    staged_full_nxt = staged_full;
    if (wrap) begin
      staged_full_nxt = 1'b0;
      if (accept) begin
        // Accept on the last phase bypasses staging straight into the next gamma cycle.
        active_nxt      = 1'b1;
        active_vals_nxt = in_values;
      end else if (staged_full) begin
        active_nxt      = 1'b1;
        active_vals_nxt = staged_vals;
      end else begin
        active_nxt      = 1'b0;
      end
    end else if (accept) begin
      staged_full_nxt = 1'b1;
    end
  end

  // Outputs are registered, so evaluate the rule against next-cycle phase and values.
  always_comb begin
    t_nxt = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
`ifdef B2T_PULSE_EN
      t_nxt[i] = active_nxt && (CMP_W'(active_vals_nxt[i]) <= p_ext) &&
                 (32'(p_ext - CMP_W'(active_vals_nxt[i])) < 32'(PULSE_WIDTH));
`else
      t_nxt[i] = active_nxt && (CMP_W'(active_vals_nxt[i]) <= p_ext);
`endif
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge aclk or posedge grst) begin
    if (grst) begin
      phase       <= '0;
      gamma_start <= 1'b1;
      active      <= 1'b0;
      t_out       <= '0;
      in_ready    <= 1'b1;
      staged_full <= 1'b0;
      // NOTE: value registers are reset too, so a discarded set can never reappear.
      active_vals <= '0;
      staged_vals <= '0;
    end else begin
      phase       <= phase_nxt;
      gamma_start <= (phase_nxt == '0);
      active      <= active_nxt;
      active_vals <= active_vals_nxt;
      t_out       <= t_nxt;
      staged_full <= staged_full_nxt;
      in_ready    <= !staged_full_nxt;
      if (accept && !wrap)
        staged_vals <= in_values;
    end
  end

endmodule

// File: tb/tb_b2t_encoder.sv
// Self-checking bench for b2t_encoder: cycle-accurate queue model plus table of per-channel edge masks.
module tb_b2t_encoder;

  localparam int G  = 16;
  localparam int NC = 16;
  localparam int VW = 8;
  localparam int PW = 8;
`ifdef B2T_PULSE_EN
  localparam bit PULSE_MODE = 1'b1;
`else
  localparam bit PULSE_MODE = 1'b0;
`endif

  typedef logic [NC-1:0][VW-1:0] set_t;
  typedef struct {
    int          ch;
    logic [7:0]  val;
    logic [15:0] exp_step;
    logic [15:0] exp_pulse;
  } vec_t;

  logic          aclk = 1'b0;
  logic          grst;
  logic          in_valid;
  logic          in_ready;
  set_t          in_values;
  logic [3:0]    phase;
  logic          gamma_start;
  logic          active;
  logic [NC-1:0] t_out;

  b2t_encoder #(
    .GAMMA_CYCLE_WIDTH(G), .PULSE_WIDTH(PW), .NUM_CHANNELS(NC), .VALUE_WIDTH(VW)
  ) dut (
    .aclk(aclk), .grst(grst), .in_valid(in_valid), .in_ready(in_ready),
    .in_values(in_values), .phase(phase), .gamma_start(gamma_start),
    .active(active), .t_out(t_out)
  );

  always #5 aclk = ~aclk;

  int   n_chk = 0;
  int   n_err = 0;
  int   n_acc = 0;
  set_t sb[$];
  set_t m_vals = '0;
  logic m_active = 1'b0;
  int   m_phase = 0;
  logic [NC-1:0] tr [G];
  vec_t tbl [10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (time %0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [NC-1:0] exp_t(input set_t v, input logic act, input int ph);
    logic [NC-1:0] r;
    for (int i = 0; i < NC; i++) begin
      int vi;
      vi = int'(v[i]);
      r[i] = act && (vi <= ph) && (!PULSE_MODE || (ph < vi + PW));
    end
    return r;
  endfunction

  function automatic set_t fill(input int ch, input logic [7:0] v);
    set_t s;
    for (int i = 0; i < NC; i++) s[i] = 8'hFF;
    s[ch] = v;
    return s;
  endfunction

  function automatic logic [15:0] mask_of(input int ch);
    logic [15:0] m;
    for (int p = 0; p < G; p++) m[p] = tr[p][ch];
    return m;
  endfunction

  // One clock: update the model across the edge, then compare every output.
  task automatic tick();
    bit acc;
    acc = in_valid && (sb.size() == 0);
    @(posedge aclk);
    if (acc) begin
      sb.push_back(in_values);
      n_acc++;
    end
    if (m_phase == G - 1) begin
      m_phase = 0;
      if (sb.size() > 0) begin
        m_vals   = sb.pop_front();
        m_active = 1'b1;
      end else begin
        m_active = 1'b0;
      end
    end else begin
      m_phase++;
    end
    #1;
    check("phase", 64'(phase), 64'(m_phase));
    check("gamma_start", 64'(gamma_start), 64'(m_phase == 0));
    check("active", 64'(active), 64'(m_active));
    check("in_ready", 64'(in_ready), 64'(sb.size() == 0));
    check("t_out", 64'(t_out), 64'(exp_t(m_vals, m_active, m_phase)));
  endtask

  // Advance to phase 0, then record t_out over one full gamma cycle.
  task automatic collect();
    int guard;
    guard = 0;
    while (m_phase != 0 && guard < 2 * G) begin
      tick();
      guard++;
    end
    for (int p = 0; p < G; p++) begin
      tr[m_phase] = t_out;
      tick();
    end
  endtask

  task automatic send(input set_t s);
    in_values = s;
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
  endtask

  initial begin
    set_t s;
    int   guard;
    int   acc0;
    logic [NC-1:0] any;

    tbl[0] = '{9,   8'd9,   16'hFE00, 16'hFE00};
    tbl[1] = '{10,  8'd10,  16'hFC00, 16'hFC00};
    tbl[2] = '{11,  8'd11,  16'hF800, 16'hF800};
    tbl[3] = '{0,   8'd0,   16'hFFFF, 16'h00FF};
    tbl[4] = '{1,   8'd15,  16'h8000, 16'h8000};
    tbl[5] = '{2,   8'd16,  16'h0000, 16'h0000};
    tbl[6] = '{7,   8'd255, 16'h0000, 16'h0000};
    tbl[7] = '{3,   8'd4,   16'hFFF0, 16'h0FF0};
    tbl[8] = '{4,   8'd2,   16'hFFFC, 16'h03FC};
    tbl[9] = '{6,   8'd12,  16'hF000, 16'hF000};

    grst      = 1'b1;
    in_valid  = 1'b0;
    in_values = '0;
    #22;
    check("rst_phase", 64'(phase), 64'd0);
    check("rst_gamma_start", 64'(gamma_start), 64'd1);
    check("rst_active", 64'(active), 64'd0);
    check("rst_t_out", 64'(t_out), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    grst = 1'b0;
    tick();

    // Table: one channel programmed per set, others out of range.
    for (int k = 0; k < 10; k++) begin
      send(fill(tbl[k].ch, tbl[k].val));
      collect();
      check($sformatf("mask_ch%0d_v%0d", tbl[k].ch, tbl[k].val), 64'(mask_of(tbl[k].ch)),
            64'(PULSE_MODE ? tbl[k].exp_pulse : tbl[k].exp_step));
    end

    // Basic step: three edges in one set, all fall at the following wrap.
    s = fill(9, 8'd9);
    s[10] = 8'd10;
    s[11] = 8'd11;
    send(s);
    collect();
    check("basic_ch9", 64'(mask_of(9)), 64'(16'hFE00));
    check("basic_ch10", 64'(mask_of(10)), 64'(16'hFC00));
    check("basic_ch11", 64'(mask_of(11)), 64'(16'hF800));
    check("basic_fall_at_wrap", 64'(t_out), 64'd0);

    // Back-pressure: hold valid with A then B; B is encoded in the gamma after A.
    tick();
    acc0      = n_acc;
    in_values = fill(0, 8'd5);
    in_valid  = 1'b1;
    tick();
    check("bp_a_accepted", 64'(n_acc - acc0), 64'd1);
    in_values = fill(0, 8'd8);
    guard = 0;
    while (n_acc < acc0 + 2 && guard < 3 * G) begin
      tick();
      guard++;
    end
    in_valid = 1'b0;
    check("bp_b_accepted_in_time", 64'(n_acc - acc0), 64'd2);
    check("bp_b_at_phase1", 64'(m_phase), 64'd1);
    collect();
    check("bp_b_mask", 64'(mask_of(0)), 64'(16'hFF00));

    // Bypass: accept on phase 15 with staging empty.
    guard = 0;
    while (m_phase != G - 1 && guard < 2 * G) begin
      tick();
      guard++;
    end
    send(fill(3, 8'd4));
    check("bypass_in_ready", 64'(in_ready), 64'd1);
    check("bypass_active", 64'(active), 64'd1);
    collect();
    check("bypass_ch3", 64'(mask_of(3)), 64'(PULSE_MODE ? 16'h0FF0 : 16'hFFF0));

    // Reset mid-gamma with v[5]=3 active.
    send(fill(5, 8'd3));
    guard = 0;
    while (!(m_active && m_phase == 7) && guard < 3 * G) begin
      tick();
      guard++;
    end
    check("rst_mid_pre_t5", 64'(t_out[5]), 64'd1);
    #1 grst = 1'b1;
    #1;
    sb.delete();
    m_active = 1'b0;
    m_vals   = '0;
    m_phase  = 0;
    check("rst_mid_t_out", 64'(t_out), 64'd0);
    check("rst_mid_phase", 64'(phase), 64'd0);
    check("rst_mid_active", 64'(active), 64'd0);
    check("rst_mid_in_ready", 64'(in_ready), 64'd1);
    #2 grst = 1'b0;
    any = '0;
    for (int p = 0; p < G + 2; p++) begin
      tick();
      any |= t_out;
    end
    check("rst_mid_no_edge", 64'(any), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
